// File: rtl/j1_boot_loader_if.sv
// Byte-stream, control and code-RAM write bundle for the j1 boot loader.
// master = host/link side, slave = boot loader.
interface j1_boot_loader_if #(
    parameter int ADDR_W = 13
);
    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_ready;
    logic              reload;
    logic              cpu_resetq;
    logic              code_we;
    logic [ADDR_W-1:0] code_waddr;
    logic [15:0]       code_wdata;
    logic              busy;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    modport master (
        output s_valid, s_data, reload,
        input  s_ready, cpu_resetq, code_we, code_waddr,
        input  code_wdata, busy, error, words_loaded
    );

    modport slave (
        input  s_valid, s_data, reload,
        output s_ready, cpu_resetq, code_we, code_waddr,
        output code_wdata, busy, error, words_loaded
    );
endinterface

// File: rtl/j1_boot_loader.sv
// j1 boot sequencer: receives LEN, N words and SUM as little-endian bytes,
// writes words to code RAM, verifies the checksum and releases the core.
module j1_boot_loader #(
    parameter int ADDR_W      = 13,
    parameter int MAX_WORDS   = 8192,
    parameter int HOLD_CYCLES = 4
) (
    input logic             clk,
    input logic             reset,
    j1_boot_loader_if.slave bus
);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [3:0] {
        S_LEN_LO,
        S_LEN_HI,
        S_DAT_LO,
        S_DAT_HI,
        S_SUM_LO,
        S_SUM_HI,
        S_HOLD,
        S_RUN,
        S_FAIL
    } state_t;

    state_t            state_q;
    logic [7:0]        lo_q;
    logic [15:0]       len_q;
    logic [15:0]       sum_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   words_q;
    logic              we_q;
    logic [15:0]       wdata_q;
    logic              resetq_q;
    logic [HW-1:0]     hold_q;

    logic [15:0]       word_d;
    logic [ADDR_W:0]   words_d;
    logic              last_d;
    logic              ready_d;

    // Word being completed by the current high byte, and next word count.
    assign word_d  = {bus.s_data, lo_q};
    assign words_d = words_q + 1'b1;
    assign last_d  = (32'(words_d) == 32'(len_q));

    // Byte-consuming states accept the stream.
    assign ready_d = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                     (state_q == S_DAT_LO) || (state_q == S_DAT_HI) ||
                     (state_q == S_SUM_LO) || (state_q == S_SUM_HI);

    assign bus.s_ready      = ready_d;
    assign bus.busy         = (state_q != S_RUN) && (state_q != S_FAIL);
    assign bus.error        = (state_q == S_FAIL);
    assign bus.cpu_resetq   = resetq_q;
    assign bus.code_we      = we_q;
    assign bus.code_waddr   = addr_q;
    assign bus.code_wdata   = wdata_q;
    assign bus.words_loaded = words_q;

    // Load FSM: byte parsing, RAM writes, checksum, hold and core release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_LEN_LO;
            lo_q     <= '0;
            len_q    <= '0;
            sum_q    <= '0;
            addr_q   <= '0;
            words_q  <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            resetq_q <= 1'b0;
            hold_q   <= '0;
        end else begin
            we_q <= 1'b0;
            if (we_q) begin
                addr_q <= addr_q + 1'b1;
            end
            unique case (state_q)
                S_LEN_LO: begin
                    if (bus.s_valid) begin
                        lo_q    <= bus.s_data;
                        state_q <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (bus.s_valid) begin
                        len_q <= word_d;
                        if (word_d == 16'd0) begin
                            state_q <= S_SUM_LO;
                        end else if (32'(word_d) > MAX_WORDS) begin
                            state_q <= S_FAIL;
                        end else begin
                            state_q <= S_DAT_LO;
                        end
                    end
                end
                S_DAT_LO: begin
                    if (bus.s_valid) begin
                        lo_q    <= bus.s_data;
                        state_q <= S_DAT_HI;
                    end
                end
                S_DAT_HI: begin
                    if (bus.s_valid) begin
                        we_q    <= 1'b1;
                        wdata_q <= word_d;
                        words_q <= words_d;
                        sum_q   <= sum_q + word_d;
                        state_q <= last_d ? S_SUM_LO : S_DAT_LO;
                    end
                end
                S_SUM_LO: begin
                    if (bus.s_valid) begin
                        lo_q    <= bus.s_data;
                        state_q <= S_SUM_HI;
                    end
                end
                S_SUM_HI: begin
                    if (bus.s_valid) begin
                        if (word_d == sum_q) begin
                            hold_q  <= '0;
                            state_q <= S_HOLD;
                        end else begin
                            state_q <= S_FAIL;
                        end
                    end
                end
                S_HOLD: begin
                    if (hold_q == HW'(HOLD_CYCLES - 1)) begin
                        resetq_q <= 1'b1;
                        state_q  <= S_RUN;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                S_RUN, S_FAIL: begin
                    if (bus.reload) begin
                        resetq_q <= 1'b0;
                        addr_q   <= '0;
                        words_q  <= '0;
                        sum_q    <= '0;
                        state_q  <= S_LEN_LO;
                    end
                end
                default: begin
                    resetq_q <= 1'b0;
                    state_q  <= S_LEN_LO;
                end
            endcase
        end
    end
endmodule
